// File: rtl/light_pkg.sv
// Shared definitions for the light selector blocks.
// Contents: FSM state enum, default parameter values, and a one-hot helper
// that maps an index to a light pattern. An index outside the light range
// maps to bit 0.
package light_pkg;

  typedef enum logic {
    IDLE,
    SHOW
  } light_state_t;

  localparam int unsigned LIGHT_NUM_LIGHTS = 16;
  localparam int unsigned LIGHT_IDX_W      = 4;
  localparam int unsigned LIGHT_TIMER_W    = 26;
  localparam int unsigned LIGHT_MAX        = 32;

  // Returns the pattern at the widest supported size. Callers truncate it to
  // their own light count.
  function automatic logic [LIGHT_MAX-1:0] onehot(input int unsigned idx,
                                                  input int unsigned n);
    logic [LIGHT_MAX-1:0] base;
    base = {{(LIGHT_MAX-1){1'b0}}, 1'b1};
    if (idx < n) onehot = base << idx;
    else         onehot = base;
  endfunction

endpackage

// File: rtl/light_select_timed_if.sv
// Interface that bundles the control, switch and light signals of
// light_select_timed.
//   master: drives start/rnd/hold_cycles/off/sw and observes the results.
//   slave : the selector itself.
// When LIGHT_SCORE_COUNT_EN is defined, the interface also carries the
// hit_count and miss_count score counters.
interface light_select_timed_if #(
  parameter int unsigned NUM_LIGHTS = 16,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned TIMER_W    = 26
);
  logic                  start;
  logic [IDX_W-1:0]      rnd;
  logic [TIMER_W-1:0]    hold_cycles;
  logic                  off;
  logic [NUM_LIGHTS-1:0] sw;
  logic [NUM_LIGHTS-1:0] out;
  logic                  busy;
  logic                  hit;
  logic                  miss;
`ifdef LIGHT_SCORE_COUNT_EN
  logic [7:0]            hit_count;
  logic [7:0]            miss_count;
`endif

  modport master (
    output start, rnd, hold_cycles, off, sw,
`ifdef LIGHT_SCORE_COUNT_EN
    input  hit_count, miss_count,
`endif
    input  out, busy, hit, miss
  );

  modport slave (
    input  start, rnd, hold_cycles, off, sw,
`ifdef LIGHT_SCORE_COUNT_EN
    output hit_count, miss_count,
`endif
    output out, busy, hit, miss
  );
endinterface

// File: rtl/light_onehot_dec.sv
// Combinational index-to-one-hot decoder. An index outside the light range
// selects bit 0.
//   i_idx    : index to decode
//   o_onehot : NUM_LIGHTS-bit one-hot pattern
module light_onehot_dec
  import light_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = LIGHT_NUM_LIGHTS,
  parameter int unsigned IDX_W      = LIGHT_IDX_W
) (
  input  logic [IDX_W-1:0]      i_idx,
  output logic [NUM_LIGHTS-1:0] o_onehot
);
  always_comb begin
    o_onehot = NUM_LIGHTS'(onehot(32'(i_idx), NUM_LIGHTS));
  end
endmodule

// File: rtl/light_select_timed.sv
// Timed one-hot light selector.
// On start (in IDLE), the block latches the target from rnd and shows it on
// the lights for hold_cycles cycles; a value of 0 counts as 1. While the
// light is shown, it reports a one-cycle hit pulse on a rising edge of the
// target switch. It reports a one-cycle miss pulse on any other rising
// switch edge, or when the window times out. The off input blanks the lights
// and freezes the round.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : light_select_timed_if.slave
//                (start, rnd, hold_cycles, off, sw -> out, busy, hit, miss)
// The optional macro LIGHT_SCORE_COUNT_EN adds the saturating 8-bit counters
// hit_count and miss_count. Only reset clears them.
module light_select_timed
  import light_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS = LIGHT_NUM_LIGHTS,
  parameter int unsigned IDX_W      = LIGHT_IDX_W,
  parameter int unsigned TIMER_W    = LIGHT_TIMER_W
) (
  input logic                   clk,
  input logic                   reset,
  light_select_timed_if.slave   bus
);
  light_state_t          r_state;
  logic [NUM_LIGHTS-1:0] r_pattern;
  logic [NUM_LIGHTS-1:0] r_sw_prev;
  logic [TIMER_W-1:0]    r_timer;
  logic                  r_hit;
  logic                  r_miss;

  logic [NUM_LIGHTS-1:0] w_target_oh;
  logic [NUM_LIGHTS-1:0] w_rise;
  logic                  w_wrong;
  logic                  w_right;
  logic [TIMER_W-1:0]    w_timer_init;

  light_onehot_dec #(
    .NUM_LIGHTS (NUM_LIGHTS),
    .IDX_W      (IDX_W)
  ) u_dec (
    .i_idx    (bus.rnd),
    .o_onehot (w_target_oh)
  );

  // The latched index is stored directly as its one-hot mask. The same
  // register both drives the lights and splits rising edges into correct
  // and wrong ones.
  always_comb begin
    w_rise       = bus.sw & ~r_sw_prev;
    w_wrong      = |(w_rise & ~r_pattern);
    w_right      = |(w_rise & r_pattern);
    w_timer_init = (bus.hold_cycles == '0) ? TIMER_W'(1) : bus.hold_cycles;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_sw_prev <= '0;
      r_timer   <= '0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_sw_prev <= bus.sw;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_pattern <= w_target_oh;
            r_timer   <= w_timer_init;
            r_state   <= SHOW;
          end
        end
        SHOW: begin
          if (!bus.off) begin
            if (w_wrong) begin
              r_miss  <= 1'b1;
              r_state <= IDLE;
            end else if (w_right) begin
              r_hit   <= 1'b1;
              r_state <= IDLE;
            end else if (r_timer == TIMER_W'(1)) begin
              r_miss  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_timer <= r_timer - TIMER_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // off blanks the lights in the same cycle, without touching the round state.
  always_comb begin
    bus.out  = (r_state == SHOW && !bus.off) ? r_pattern : '0;
    bus.busy = (r_state == SHOW);
    bus.hit  = r_hit;
    bus.miss = r_miss;
  end

`ifdef LIGHT_SCORE_COUNT_EN
  logic [7:0] r_hit_count;
  logic [7:0] r_miss_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (r_hit && r_hit_count != 8'hFF)   r_hit_count  <= r_hit_count + 8'd1;
      if (r_miss && r_miss_count != 8'hFF) r_miss_count <= r_miss_count + 8'd1;
    end
  end

  always_comb begin
    bus.hit_count  = r_hit_count;
    bus.miss_count = r_miss_count;
  end
`endif

endmodule

// File: tb/tb_light_select_timed.sv
module tb_light_select_timed;
  localparam int NL = 16;

  logic clk = 1'b0;
  logic reset;
  bit   check_en = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  light_select_timed_if #(.NUM_LIGHTS(16), .IDX_W(5), .TIMER_W(8)) bus ();

  light_select_timed #(.NUM_LIGHTS(16), .IDX_W(5), .TIMER_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0] d_idx;
  logic [9:0] d_oh;
  light_onehot_dec #(.NUM_LIGHTS(10), .IDX_W(4)) dec10 (
    .i_idx    (d_idx),
    .o_onehot (d_oh)
  );

  // Behavioural model: a round is active or not. It has a target light and a
  // number of remaining display cycles. Pulses are flags set on the clock
  // edge that ends the round.
  int        m_show = 0;
  int        m_target = 0;
  int        m_remaining = 0;
  bit        m_hit = 1'b0;
  bit        m_miss = 1'b0;
  int        m_hc = 0;
  int        m_mc = 0;
  logic [NL-1:0] m_prev_sw = '0;
  logic [NL-1:0] m_rise;
  logic [NL-1:0] m_other;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_show = 0; m_target = 0; m_remaining = 0;
      m_hit = 1'b0; m_miss = 1'b0; m_hc = 0; m_mc = 0;
      m_prev_sw = '0;
    end else begin
      if (m_hit && m_hc < 255) m_hc++;
      if (m_miss && m_mc < 255) m_mc++;
      m_rise = bus.sw & ~m_prev_sw;
      m_hit = 1'b0;
      m_miss = 1'b0;
      if (m_show == 0) begin
        if (bus.start) begin
          m_show = 1;
          m_target = (int'(bus.rnd) < NL) ? int'(bus.rnd) : 0;
          m_remaining = (bus.hold_cycles == 0) ? 1 : int'(bus.hold_cycles);
        end
      end else if (!bus.off) begin
        m_other = m_rise;
        m_other[m_target] = 1'b0;
        if (m_other != 0) m_miss = 1'b1;
        else if (m_rise[m_target]) m_hit = 1'b1;
        else if (m_remaining == 1) m_miss = 1'b1;
        else m_remaining--;
        if (m_hit || m_miss) m_show = 0;
      end
      m_prev_sw = bus.sw;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic [NL-1:0] e_out;
      e_out = (m_show != 0 && bus.off == 1'b0) ? NL'(1 << m_target) : '0;
      check("model_out",  32'(bus.out),  32'(e_out));
      check("model_busy", 32'(bus.busy), 32'(m_show != 0));
      check("model_hit",  32'(bus.hit),  32'(m_hit));
      check("model_miss", 32'(bus.miss), 32'(m_miss));
`ifdef LIGHT_SCORE_COUNT_EN
      check("model_hit_count",  32'(bus.hit_count),  32'(m_hc));
      check("model_miss_count", 32'(bus.miss_count), 32'(m_mc));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic peek();
    #3;
  endtask

  task automatic launch(input int idx, input int hold);
    bus.start = 1'b1;
    bus.rnd = 5'(idx);
    bus.hold_cycles = 8'(hold);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.rnd = '0; bus.hold_cycles = '0; bus.off = 1'b0; bus.sw = '0;
    tick();
    check_en = 1'b1;
    tick();
    peek();
    check("reset_out", 32'(bus.out), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_hit", 32'(bus.hit), 0);
    check("reset_miss", 32'(bus.miss), 0);
    tick();
    reset = 1'b0;
    tick();

    // Show index 5, then hit it on the third shown cycle.
    launch(5, 10);
    peek();
    check("show5_out", 32'(bus.out), 32'h0020);
    check("show5_busy", 32'(bus.busy), 1);
    tick(); tick();
    bus.sw = 16'h0020;
    tick();
    peek();
    check("hit5_hit", 32'(bus.hit), 1);
    check("hit5_out", 32'(bus.out), 0);
    check("hit5_busy", 32'(bus.busy), 0);
    check("hit5_miss", 32'(bus.miss), 0);
    bus.sw = '0;
    tick();
    peek();
    check("hit5_once", 32'(bus.hit), 0);
    tick();

    // Timeout after four shown cycles.
    launch(2, 4);
    for (int i = 0; i < 3; i++) begin
      peek();
      check("to2_out", 32'(bus.out), 32'h0004);
      check("to2_nomiss", 32'(bus.miss), 0);
      tick();
    end
    peek();
    check("to2_out4", 32'(bus.out), 32'h0004);
    tick();
    peek();
    check("to2_miss", 32'(bus.miss), 1);
    check("to2_out_off", 32'(bus.out), 0);
    tick();

    // Correct and wrong switch raised together, then the wrong one alone.
    launch(7, 50);
    bus.sw = 16'h0088;
    tick();
    peek();
    check("both_miss", 32'(bus.miss), 1);
    check("both_hit", 32'(bus.hit), 0);
    bus.sw = '0;
    tick(); tick();
    launch(7, 50);
    bus.sw = 16'h0008;
    tick();
    peek();
    check("wrong_miss", 32'(bus.miss), 1);
    bus.sw = '0;
    tick(); tick();

    // Pause for 20 cycles partway through the window.
    launch(9, 6);
    peek();
    check("pause_pre", 32'(bus.out), 32'h0200);
    tick(); tick();
    bus.off = 1'b1;
    for (int i = 0; i < 20; i++) begin
      peek();
      check("pause_out", 32'(bus.out), 0);
      check("pause_pulse", 32'({bus.hit, bus.miss}), 0);
      tick();
    end
    bus.off = 1'b0;
    for (int i = 0; i < 4; i++) begin
      peek();
      check("pause_post", 32'(bus.out), 32'h0200);
      check("pause_nomiss", 32'(bus.miss), 0);
      tick();
    end
    peek();
    check("pause_miss", 32'(bus.miss), 1);
    tick();

    // Zero hold shows the light for one cycle.
    launch(1, 0);
    peek();
    check("h0_out", 32'(bus.out), 32'h0002);
    tick();
    peek();
    check("h0_miss", 32'(bus.miss), 1);
    tick();

    // An out-of-range index lights bit 0.
    launch(20, 3);
    peek();
    check("oor_out", 32'(bus.out), 32'h0001);
    tick(); tick(); tick(); tick();

    // Reset during a round produces no pulse.
    launch(4, 10);
    tick();
    reset = 1'b1;
    peek();
    check("rst_mid_out", 32'(bus.out), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      peek();
      check("rst_mid_pulse", 32'({bus.hit, bus.miss}), 0);
      tick();
    end

    // Decoder with 10 lights, over the whole index range.
    for (int i = 0; i < 16; i++) begin
      d_idx = 4'(i);
      #1;
      check("dec10", 32'(d_oh), (i < 10) ? (32'h1 << i) : 32'h1);
    end
    tick();

    // Randomised play.
    for (int c = 0; c < 3000; c++) begin
      bus.start = ($urandom_range(3, 0) == 0);
      bus.rnd = 5'($urandom_range(31, 0));
      bus.hold_cycles = 8'($urandom_range(12, 0));
      if ($urandom_range(9, 0) == 0) bus.off = ~bus.off;
      if ($urandom_range(4, 0) == 0) begin
        if (m_show != 0 && $urandom_range(1, 0) == 1) bus.sw[m_target] = ~bus.sw[m_target];
        else bus.sw[$urandom_range(NL-1, 0)] = ~bus.sw[$urandom_range(NL-1, 0)];
      end
      reset = ($urandom_range(399, 0) == 0);
      tick();
    end
    reset = 1'b0; bus.start = 1'b0; bus.off = 1'b0; bus.sw = '0;
    tick();

`ifdef LIGHT_SCORE_COUNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int r = 0; r < 260; r++) begin
      launch(3, 5);
      bus.sw = 16'h0008;
      tick();
      bus.sw = '0;
      tick();
    end
    tick();
    peek();
    check("hit_count_sat", 32'(bus.hit_count), 255);
    check("miss_count_zero", 32'(bus.miss_count), 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
